// File: rtl/rv32_types_pkg.sv
// Shared types and constants for the RV32 fetch front end.
package rv32_types;

    typedef logic [31:0] rv_instr_t;

    // addi x0, x0, 0 -- what decode sees whenever no real instruction is presented
    localparam rv_instr_t RV_NOP_INSTR = 32'h0000_0013;

    // Byte distance between consecutive instruction words
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // One fetched instruction together with the address it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        rv_instr_t   instr;
    } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop and flush.
// Flush has priority over push and pop. A push while full is accepted only
// when a pop frees a slot in the same cycle.
module rv32_fetch_fifo
    import rv32_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against the current occupancy
    always_comb begin
        full    = (count_q == CNT_W'(DEPTH));
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && (!full || do_pop);
    end

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/rv32_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues word requests under a
// credit limit, pairs in-order responses with their PCs and presents them to
// decode. A redirect flushes buffered instructions and marks in-flight ones
// for discard.
module rv32_fetch_unit
    import rv32_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        decode_ready,
    output logic        instr_valid,
    output rv_instr_t   instr,
    output logic [31:0] instr_pc,
    output logic        set_nop
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic             started_q;

    // The addr queue holds exactly one entry per outstanding request, so its
    // occupancy doubles as the in-flight counter.
    fetch_entry_t     addr_entry, addr_head;
    logic             addr_empty;
    logic [CNT_W-1:0] in_flight;

    fetch_entry_t     rsp_entry, instr_head;
    logic             instr_empty;
    logic [CNT_W-1:0] fifo_count;

    logic [CNT_W:0]   occupancy;
    logic             req_accept, rsp_take, rsp_drop, instr_push, instr_pop;

    // Credit check, handshakes and the entries pushed into each queue
    always_comb begin
        occupancy      = {1'b0, in_flight} + {1'b0, fifo_count};
        imem_req_valid = started_q && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
        req_accept     = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && !addr_empty;
        rsp_drop       = redirect_valid || (kill_cnt_q != '0);
        instr_push     = rsp_take && !rsp_drop;
        instr_pop      = !instr_empty && decode_ready;
        addr_entry       = '0;
        addr_entry.pc    = fetch_pc_q;
        addr_entry.instr = RV_NOP_INSTR;
        rsp_entry        = addr_head;
        rsp_entry.instr  = imem_rsp_data;
    end

    // Next fetch PC and discard count; a redirect overrides everything else
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        kill_cnt_d = kill_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~(INSTR_BYTES - 32'd1);
            kill_cnt_d = in_flight - CNT_W'(rsp_take);
        end else begin
            if (req_accept) begin
                fetch_pc_d = fetch_pc_q + INSTR_BYTES;
            end
            if (rsp_take && (kill_cnt_q != '0)) begin
                kill_cnt_d = kill_cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers; started_q keeps requests quiet for the first cycle out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            kill_cnt_q <= '0;
            started_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            kill_cnt_q <= kill_cnt_d;
            started_q  <= 1'b1;
        end
    end

    rv32_fetch_fifo #(.DEPTH(DEPTH)) u_addr_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_accept),
        .push_data_i (addr_entry),
        .pop_i       (rsp_take),
        .flush_i     (1'b0),
        .head_o      (addr_head),
        .empty_o     (addr_empty),
        .count_o     (in_flight)
    );

    rv32_fetch_fifo #(.DEPTH(DEPTH)) u_instr_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (instr_push),
        .push_data_i (rsp_entry),
        .pop_i       (instr_pop),
        .flush_i     (redirect_valid),
        .head_o      (instr_head),
        .empty_o     (instr_empty),
        .count_o     (fifo_count)
    );

    assign imem_req_addr = fetch_pc_q;
    assign instr_valid   = !instr_empty;
    assign set_nop       = instr_empty;
    assign instr         = instr_empty ? RV_NOP_INSTR : instr_head.instr;
    assign instr_pc      = instr_empty ? RESET_PC : instr_head.pc;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Directed testbench for rv32_fetch_unit with a simple in-order memory model.
module tb_rv32_fetch_unit;
   import rv32_types::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        decode_ready = 1'b0;
   logic        instr_valid;
   rv_instr_t   instr;
   logic [31:0] instr_pc;
   logic        set_nop;

   int checkCount = 0;
   int failCount = 0;

   int          memLat = 1;
   int          cycleNum = 0;
   int          acceptCnt = 0;
   logic [31:0] pendAddr[$];
   int          pendDue[$];
   logic [31:0] accAddr[$];
   logic [31:0] gotPc[$];
   logic [31:0] gotInstr[$];

   rv32_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .decode_ready   (decode_ready),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .set_nop        (set_nop)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Instruction word the memory model returns for an address
   function automatic logic [31:0] memData(input logic [31:0] a);
      return a ^ 32'h00A0_0093;
   endfunction

   // Memory model and decode monitor: drive responses on the falling edge,
   // sample handshakes one time unit before the next rising edge
   always @(negedge clk) begin
      if (rst) begin
         pendAddr.delete();
         pendDue.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end else if (pendAddr.size() > 0 && pendDue[0] <= cycleNum) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memData(pendAddr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
      #4;
      if (rst) begin
         pendAddr.delete();
         pendDue.delete();
         imem_rsp_valid = 1'b0;
      end else begin
         checkOutput("setNopIsNotValid", {31'b0, set_nop}, {31'b0, ~instr_valid});
         if (imem_rsp_valid) begin
            void'(pendAddr.pop_front());
            void'(pendDue.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            pendAddr.push_back(imem_req_addr);
            pendDue.push_back(cycleNum + memLat);
            accAddr.push_back(imem_req_addr);
            acceptCnt++;
         end
         if (instr_valid && decode_ready) begin
            gotPc.push_back(instr_pc);
            gotInstr.push_back(instr);
         end
         cycleNum++;
      end
   end

   // Drive all control inputs for one cycle starting at the falling edge
   task automatic applyStimulus(input logic redirV, input logic [31:0] redirPc, input logic decRdy, input logic memRdy);
      @(negedge clk);
      redirect_valid = redirV;
      redirect_pc    = redirPc;
      decode_ready   = decRdy;
      imem_req_ready = memRdy;
   endtask

   // Compare every output against its reset value
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_reqValid"}, {31'b0, imem_req_valid}, 32'h0);
      checkOutput({tag, "_reqAddr"}, imem_req_addr, 32'h0);
      checkOutput({tag, "_instrValid"}, {31'b0, instr_valid}, 32'h0);
      checkOutput({tag, "_instr"}, instr, 32'h0000_0013);
      checkOutput({tag, "_instrPc"}, instr_pc, 32'h0);
      checkOutput({tag, "_setNop"}, {31'b0, set_nop}, 32'h1);
   endtask

   // Hold reset for two cycles, clear bench bookkeeping, release
   task automatic doReset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      decode_ready   = 1'b0;
      imem_req_ready = 1'b1;
      memLat         = 1;
      #1 checkResetOutputs(tag);
      @(negedge clk);
      @(negedge clk);
      acceptCnt = 0;
      accAddr.delete();
      gotPc.delete();
      gotInstr.delete();
      rst = 1'b0;
      #1 checkOutput({tag, "_firstCycleReqValid"}, {31'b0, imem_req_valid}, 32'h0);
   endtask

   // Run with decode and memory ready until n instructions were delivered
   task automatic waitDeliveries(input int n, input int budget, input string tag);
      int k = 0;
      while (gotPc.size() < n && k < budget) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
         k++;
      end
      if (gotPc.size() < n) checkOutput({tag, "_deliveryTimeout"}, 32'(gotPc.size()), 32'(n));
   endtask

   // Wait on falling edges until the accept count reaches n, inputs unchanged
   task automatic waitAccepts(input int n, input int budget, input string tag);
      int k = 0;
      while (acceptCnt < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (acceptCnt < n) checkOutput({tag, "_acceptTimeout"}, 32'(acceptCnt), 32'(n));
   endtask

   // Compare delivered PCs and words against an expected address list
   task automatic checkDelivered(input string tag, input logic [31:0] exp0, input logic [31:0] exp1);
      if (gotPc.size() >= 2) begin
         checkOutput({tag, "_pc0"}, gotPc[0], exp0);
         checkOutput({tag, "_instr0"}, gotInstr[0], memData(exp0));
         checkOutput({tag, "_pc1"}, gotPc[1], exp1);
         checkOutput({tag, "_instr1"}, gotInstr[1], memData(exp1));
      end
   endtask

   initial begin
      int k;

      // Streaming after reset with single-cycle memory
      doReset("reset");
      decode_ready = 1'b1;
      waitDeliveries(6, 40, "stream");
      if (gotPc.size() >= 6) begin
         for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("stream_pc%0d", i), gotPc[i], 32'(4 * i));
            checkOutput($sformatf("stream_instr%0d", i), gotInstr[i], memData(32'(4 * i)));
         end
      end

      // Decode stalled for five cycles: two requests, head held at 0x0
      doReset("stallRst");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checkOutput("stall_acceptCnt", 32'(acceptCnt), 32'd2);
      checkOutput("stall_reqValid", {31'b0, imem_req_valid}, 32'h0);
      checkOutput("stall_instrValid", {31'b0, instr_valid}, 32'h1);
      checkOutput("stall_headPc", instr_pc, 32'h0);
      checkOutput("stall_headInstr", instr, memData(32'h0));
      waitDeliveries(3, 20, "stallRelease");
      if (gotPc.size() >= 3) begin
         checkDelivered("stallRelease", 32'h0, 32'h4);
         checkOutput("stallRelease_pc2", gotPc[2], 32'h8);
      end

      // Memory not ready for three cycles: address held at 0x8
      doReset("readyRst");
      decode_ready = 1'b1;
      waitAccepts(2, 10, "ready");
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 checkOutput($sformatf("ready_addrHeld%0d", i), imem_req_addr, 32'h8);
         @(negedge clk);
         checkOutput($sformatf("ready_noAccept%0d", i), 32'(acceptCnt), 32'd2);
      end
      imem_req_ready = 1'b1;
      waitAccepts(3, 10, "readyBack");
      if (accAddr.size() >= 3) checkOutput("readyBack_addr", accAddr[2], 32'h8);
      waitDeliveries(3, 20, "readyBack");
      if (gotPc.size() >= 3) begin
         checkDelivered("readyBack", 32'h0, 32'h4);
         checkOutput("readyBack_pc2", gotPc[2], 32'h8);
      end

      // Redirect to 0x100 with two requests in flight, latency three
      doReset("redirRst");
      memLat = 3;
      decode_ready = 1'b1;
      waitAccepts(2, 10, "redir");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      #1 checkOutput("redir_noReq", {31'b0, imem_req_valid}, 32'h0);
      @(negedge clk);
      redirect_valid = 1'b0;
      gotPc.delete();
      gotInstr.delete();
      waitDeliveries(2, 40, "redir");
      checkDelivered("redir", 32'h100, 32'h104);

      // Redirect to 0x203 coinciding with a response and a decode pop
      doReset("sameRst");
      decode_ready = 1'b1;
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         #1;
         if (imem_rsp_valid && instr_valid) break;
         k++;
      end
      checkOutput("same_found", {31'b0, imem_rsp_valid && instr_valid}, 32'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      @(negedge clk);
      redirect_valid = 1'b0;
      gotPc.delete();
      gotInstr.delete();
      #1;
      checkOutput("same_emptyAfter", {31'b0, instr_valid}, 32'h0);
      checkOutput("same_nextAddr", imem_req_addr, 32'h200);
      checkOutput("same_reqValid", {31'b0, imem_req_valid}, 32'h1);
      waitDeliveries(2, 20, "same");
      checkDelivered("same", 32'h200, 32'h204);

      // Fetch PC wraps from 0xFFFF_FFFC to 0x0
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      accAddr.delete();
      gotPc.delete();
      gotInstr.delete();
      k = 0;
      while (accAddr.size() < 2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput("wrap_acceptCount", 32'(accAddr.size() >= 2), 32'h1);
      if (accAddr.size() >= 2) begin
         checkOutput("wrap_addr0", accAddr[0], 32'hFFFF_FFFC);
         checkOutput("wrap_addr1", accAddr[1], 32'h0);
      end
      waitDeliveries(2, 20, "wrap");
      checkDelivered("wrap", 32'hFFFF_FFFC, 32'h0);

      // Asynchronous reset pulse in the middle of the stream
      @(negedge clk);
      #2 rst = 1'b1;
      #1 checkResetOutputs("midReset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 checkOutput("midReset_firstCycleReqValid", {31'b0, imem_req_valid}, 32'h0);
      @(negedge clk);
      #1 checkOutput("midReset_reqAfter", {31'b0, imem_req_valid}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

   // Safety net against a hung run
   initial begin
      #100000;
      failCount++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/rv32_fetch_unit.md
Name: rv32_fetch_unit

Overview:
Instruction fetch front end that produces the `instr` / `set_nop` stream consumed by the decode stage. It owns the fetch PC and issues word requests to instruction memory. Responses are buffered in order, each paired with its PC, and handed to decode under a valid/ready handshake. Branch/jump redirects from execute flush the buffered and in-flight instructions.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
DEPTH, 2, maximum requests in flight plus buffered instructions (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid (in order, ≥1 cycle after acceptance)
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  PC redirect from execute
redirect_pc  in  32  redirect target
decode_ready  in  1  decode accepts instruction this cycle
instr_valid  out  1  buffered instruction presented
instr  out  32  rv_instr_t to decode
instr_pc  out  32  PC of `instr`
set_nop  out  1  equals ~instr_valid; drives decoder set_nop

Behaviour:
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - instr_valid=0, instr=RV_NOP_INSTR (32'h0000_0013), instr_pc=RESET_PC, set_nop=1.
  - Counters and FIFO are cleared.
- State:
  - fetch_pc register.
  - in_flight counter (0..DEPTH): accepted requests with no response yet.
  - kill_cnt (0..DEPTH): responses still to be discarded.
  - addr queue (DEPTH entries): PCs of outstanding requests.
  - instruction FIFO (DEPTH entries of {pc, instr}).
- Credit rule: imem_req_valid = ~redirect_valid && (in_flight + fifo_count < DEPTH). It is combinational, and low in the first cycle after reset.
- Request issue:
  - A request is accepted when imem_req_valid && imem_req_ready.
  - On acceptance: push fetch_pc to the addr queue, fetch_pc += 4 (wraps modulo 2^32), in_flight++.
  - imem_req_addr = fetch_pc, held stable while ready is low.
- Response handling:
  - Every response decrements in_flight and pops the addr queue.
  - If kill_cnt>0: the response is dropped and kill_cnt decrements.
  - Otherwise: {popped pc, data} is pushed to the FIFO.
  - Response-to-instr_valid latency: 1 cycle.
  - A response with in_flight==0 is a protocol violation: ignored, and flagged by bench assertion.
- Decode handshake:
  - instr, instr_pc and instr_valid come from the FIFO head.
  - Pop on instr_valid && decode_ready.
  - Head is held stable while decode_ready=0.
  - When empty, instr=RV_NOP_INSTR.
- Redirect (highest priority), in the cycle redirect_valid=1:
  - fetch_pc := {redirect_pc[31:2], 2'b00}; low bits are ignored.
  - FIFO is flushed; a simultaneous pop is void.
  - kill_cnt := in_flight − (imem_rsp_valid ? 1 : 0); a same-cycle response is dropped.
  - No request is issued that cycle.
  - The next cycle issues from the redirect target, even while kill_cnt>0.
- Full/empty:
  - The credit rule makes FIFO overflow impossible, and also bounds kill_cnt.
  - Back-to-back push and pop at full occupancy is permitted.
- Reset mid-operation: all state clears immediately. Late responses after reset are protocol violations (memory is reset together with this block).

Decomposition:
- rv32_types package:
  - RV_NOP_INSTR constant.
  - fetch_entry_t struct {logic [31:0] pc; rv_instr_t instr;}.
  - INSTR_BYTES=4 constant.
- Sub-module rv32_fetch_fifo:
  - Parametric synchronous FIFO of fetch_entry_t with push, pop and flush.
  - Outputs count, empty and head.
  - Flush wins over push and pop.
  - Instantiated twice: addr queue (instr field unused) and instruction FIFO.

Test Plan:
- Reset release, memory with 1-cycle latency, decode_ready=1 → requests at 0x0, 0x4, 0x8…; instr_pc sequence 0x0, 0x4, … with set_nop=0 after the first response; set_nop=1 before it.
- decode_ready=0 for 5 cycles → at most 2 requests outstanding/buffered; head holds pc=0x0; on release, 0x0 and 0x4 are delivered in order with no loss or duplication.
- imem_req_ready=0 for 3 cycles → imem_req_addr stays 0x8 and in_flight stays unchanged; accepted once ready returns.
- Redirect to 0x100 with 2 in flight, memory latency 3 → both stale responses dropped; next instr_pc=0x100, then 0x104.
- Redirect to 0x203 in the same cycle as a response and a decode pop → response discarded, FIFO empty next cycle, next request address 0x200.
- fetch_pc=0xFFFF_FFFC → next request address 0x0000_0000; rst pulsed mid-stream → outputs return to reset values in the same cycle.
